if_id_decode_stage: RTL and testbench

- Decode stage directly downstream of instruction fetch in the pipelined LEGv8 core.
- Holds the IF/ID pipeline register and decodes the fetched 32-bit instruction into control signals and operand fields.
- Resolves B, B.LT and CBZ in ID and drives BrTaken/UncondBr back to fetch; detects load-use hazards.
- Outputs a registered ID/EX control bundle.

---
 rtl/if_id_decode_stage.sv | 195 +++++++++++++++++++
 tb/tb_if_id_decode_stage.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_decode_stage.sv
// LEGv8 IF/ID pipeline register, instruction decode, ID-stage branch resolution,
// load-use stall detection and ID/EX register. Optional macro: ILLEGAL_TRAP_EN.
module if_id_decode_stage #(
  parameter int         PC_W     = 64,
  parameter logic [4:0] ZERO_REG = 5'd31
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     if_instr,
  input  logic [PC_W-1:0] if_pc,
  input  logic            if_valid,
  input  logic [3:0]      ex_flags,
  input  logic            ex_flags_we,
  input  logic            rt_zero,
  output logic [4:0]      rd_addr1,
  output logic [4:0]      rd_addr2,
  output logic            stall_out,
  output logic            BrTaken,
  output logic            UncondBr,
  output logic [PC_W-1:0] id_pc,
  output logic            ex_valid,
  output logic [PC_W-1:0] ex_pc,
  output logic [4:0]      ex_rd,
  output logic [PC_W-1:0] ex_imm,
  output logic [5:0]      ex_shamt,
  output logic [2:0]      ex_alu_op,
  output logic            ex_alu_src,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_reg_write,
  output logic            ex_set_flags,
  output logic            illegal_op
);

  typedef enum logic [3:0] {
    C_NOP, C_ADDI, C_ADDS, C_SUBS, C_AND, C_EOR, C_LSR,
    C_LDUR, C_STUR, C_B, C_BCOND, C_CBZ
  } op_class_e;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic [4:0]      rd;
    logic [PC_W-1:0] imm;
    logic [5:0]      shamt;
    logic [2:0]      alu_op;
    logic            alu_src;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            reg_write;
    logic            set_flags;
  } idex_t;

  logic [31:0]     r_instr;
  logic [PC_W-1:0] r_pc;
  logic            r_valid;
  logic [3:0]      r_flags;
  idex_t           r_idex;
  idex_t           w_dec;
  op_class_e       w_class;
  logic            w_uses_rn;
  logic            w_uses_r2;
  logic            w_load_use;
  logic [3:0]      w_flags_byp;
  logic [PC_W-1:0] w_imm12;
  logic [PC_W-1:0] w_imm9;

  always_comb begin
    w_class = C_NOP;
    if (r_instr[31:22] == 10'h244)     w_class = C_ADDI;
    else if (r_instr[31:26] == 6'h05)  w_class = C_B;
    else if (r_instr[31:24] == 8'h54)  w_class = C_BCOND;
    else if (r_instr[31:24] == 8'hB4)  w_class = C_CBZ;
    else begin
      case (r_instr[31:21])
        11'h558: w_class = C_ADDS;
        11'h758: w_class = C_SUBS;
        11'h450: w_class = C_AND;
        11'h650: w_class = C_EOR;
        11'h69A: w_class = C_LSR;
        11'h7C2: w_class = C_LDUR;
        11'h7C0: w_class = C_STUR;
        default: w_class = C_NOP;
      endcase
    end
  end

  assign w_imm12 = {{(PC_W-12){1'b0}}, r_instr[21:10]};
  assign w_imm9  = {{(PC_W-9){r_instr[20]}}, r_instr[20:12]};

  // Reg2Loc: stores and CBZ read Rt through the second port
  assign rd_addr1  = r_instr[9:5];
  assign rd_addr2  = (w_class == C_STUR || w_class == C_CBZ) ? r_instr[4:0] : r_instr[20:16];
  assign w_uses_rn = w_class inside {C_ADDI, C_ADDS, C_SUBS, C_AND, C_EOR, C_LSR, C_LDUR, C_STUR};
  assign w_uses_r2 = w_class inside {C_ADDS, C_SUBS, C_AND, C_EOR, C_STUR, C_CBZ};

  assign w_load_use = r_valid && r_idex.mem_read && (r_idex.rd != ZERO_REG) &&
                      ((w_uses_rn && rd_addr1 == r_idex.rd) ||
                       (w_uses_r2 && rd_addr2 == r_idex.rd));
  assign stall_out  = w_load_use;
  assign id_pc      = r_pc;

  // Flags from the instruction currently in EX win over the stored copy
  assign w_flags_byp = ex_flags_we ? ex_flags : r_flags;

  always_comb begin
    BrTaken  = 1'b0;
    UncondBr = 1'b0;
    if (r_valid && !w_load_use) begin
      case (w_class)
        C_B: begin
          BrTaken  = 1'b1;
          UncondBr = 1'b1;
        end
        C_BCOND: BrTaken = (r_instr[3:0] == 4'hB) && (w_flags_byp[3] != w_flags_byp[0]);
        C_CBZ:   BrTaken = rt_zero;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_dec = '0;
    if (r_valid && w_class != C_NOP) begin
      w_dec.valid = 1'b1;
      w_dec.pc    = r_pc;
      if (!(w_class inside {C_B, C_BCOND, C_CBZ})) w_dec.rd = r_instr[4:0];
      case (w_class)
        C_ADDI: begin
          w_dec.imm = w_imm12; w_dec.alu_src = 1'b1; w_dec.alu_op = 3'b010; w_dec.reg_write = 1'b1;
        end
        C_ADDS: begin w_dec.alu_op = 3'b010; w_dec.reg_write = 1'b1; w_dec.set_flags = 1'b1; end
        C_SUBS: begin w_dec.alu_op = 3'b011; w_dec.reg_write = 1'b1; w_dec.set_flags = 1'b1; end
        C_AND:  begin w_dec.alu_op = 3'b100; w_dec.reg_write = 1'b1; end
        C_EOR:  begin w_dec.alu_op = 3'b110; w_dec.reg_write = 1'b1; end
        C_LSR:  begin w_dec.shamt = r_instr[15:10]; w_dec.reg_write = 1'b1; end
        C_LDUR: begin
          w_dec.imm = w_imm9; w_dec.alu_src = 1'b1; w_dec.alu_op = 3'b010;
          w_dec.mem_read = 1'b1; w_dec.mem_to_reg = 1'b1; w_dec.reg_write = 1'b1;
        end
        C_STUR: begin
          w_dec.imm = w_imm9; w_dec.alu_src = 1'b1; w_dec.alu_op = 3'b010; w_dec.mem_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
      r_flags <= '0;
      r_idex  <= '0;
    end else begin
      if (ex_flags_we && r_idex.valid) r_flags <= ex_flags;
      if (w_load_use) begin
        r_idex <= '0;
      end else begin
        r_idex  <= w_dec;
        r_instr <= if_instr;
        r_pc    <= if_pc;
        r_valid <= if_valid && !BrTaken;
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge clk) begin
    if (reset) r_illegal <= 1'b0;
    else if (r_valid && w_class == C_NOP) r_illegal <= 1'b1;
  end
  assign illegal_op = r_illegal;
`else
  assign illegal_op = 1'b0;
`endif

  assign ex_valid      = r_idex.valid;
  assign ex_pc         = r_idex.pc;
  assign ex_rd         = r_idex.rd;
  assign ex_imm        = r_idex.imm;
  assign ex_shamt      = r_idex.shamt;
  assign ex_alu_op     = r_idex.alu_op;
  assign ex_alu_src    = r_idex.alu_src;
  assign ex_mem_read   = r_idex.mem_read;
  assign ex_mem_write  = r_idex.mem_write;
  assign ex_mem_to_reg = r_idex.mem_to_reg;
  assign ex_reg_write  = r_idex.reg_write;
  assign ex_set_flags  = r_idex.set_flags;

endmodule

// File: tb/tb_if_id_decode_stage.sv
// Directed scenarios plus a randomized run against a transaction-level model.
module tb_if_id_decode_stage;
  localparam int PC_W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, if_valid, ex_flags_we, rt_zero;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic [3:0]  ex_flags;
  logic [4:0]  rd_addr1, rd_addr2, ex_rd;
  logic        stall_out, BrTaken, UncondBr, illegal_op;
  logic [63:0] id_pc, ex_pc, ex_imm;
  logic [5:0]  ex_shamt;
  logic [2:0]  ex_alu_op;
  logic        ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_set_flags;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_ill_en;

  if_id_decode_stage #(.PC_W(PC_W), .ZERO_REG(5'd31)) dut (
    .clk(clk), .reset(reset), .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
    .ex_flags(ex_flags), .ex_flags_we(ex_flags_we), .rt_zero(rt_zero),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .stall_out(stall_out), .BrTaken(BrTaken),
    .UncondBr(UncondBr), .id_pc(id_pc), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_imm(ex_imm), .ex_shamt(ex_shamt), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_write(ex_reg_write), .ex_set_flags(ex_set_flags), .illegal_op(illegal_op)
  );

  // Instruction assemblers
  function automatic logic [31:0] e_addi(input logic [4:0] rd, input logic [4:0] rn, input logic [11:0] imm);
    return {10'h244, imm, rn, rd};
  endfunction
  function automatic logic [31:0] e_r(input logic [10:0] op, input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
    return {op, rm, 6'd0, rn, rd};
  endfunction
  function automatic logic [31:0] e_d(input logic [10:0] op, input logic [4:0] rt, input logic [4:0] rn, input logic [8:0] imm9);
    return {op, imm9, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] e_b(input logic [25:0] imm26);
    return {6'h05, imm26};
  endfunction
  function automatic logic [31:0] e_bc(input logic [18:0] imm19, input logic [3:0] cond);
    return {8'h54, imm19, 1'b0, cond};
  endfunction
  function automatic logic [31:0] e_cbz(input logic [18:0] imm19, input logic [4:0] rt);
    return {8'hB4, imm19, rt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [63:0] pc, input logic v);
    if_instr = ins; if_pc = pc; if_valid = v;
  endtask

  task automatic flush();
    drive(32'd0, 64'd0, 1'b0);
    ex_flags_we = 1'b0; rt_zero = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    drive(e_r(11'h558, 5'd1, 5'd2, 5'd3), 64'h10, 1'b1);
    tick();
    drive(e_d(11'h7C2, 5'd4, 5'd5, 9'd8), 64'h14, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ex_valid got=%0h exp=0", ex_valid); end
    n_checks++; if ({ex_pc, ex_rd, ex_imm, ex_shamt, ex_alu_op} !== '0) begin n_fail++; $display("FAIL rst_ex_fields got nonzero"); end
    n_checks++; if ({ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_set_flags} !== 6'd0) begin
      n_fail++; $display("FAIL rst_ex_ctrl got=%b exp=000000", {ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_set_flags}); end
    n_checks++; if ({stall_out, BrTaken, UncondBr, illegal_op} !== 4'd0) begin
      n_fail++; $display("FAIL rst_comb got=%b exp=0000", {stall_out, BrTaken, UncondBr, illegal_op}); end
  endtask

  task automatic test_addi();
    drive(e_addi(5'd1, 5'd0, 12'd5), 64'h40, 1'b1);
    tick();
    n_checks++; if (id_pc !== 64'h40) begin n_fail++; $display("FAIL addi_id_pc got=%0h exp=40", id_pc); end
    n_checks++; if (rd_addr1 !== 5'd0) begin n_fail++; $display("FAIL addi_rd_addr1 got=%0d exp=0", rd_addr1); end
    drive(32'd0, 64'd0, 1'b0);
    tick();
    n_checks++; if ({ex_valid, ex_rd, ex_alu_src, ex_alu_op, ex_reg_write} !== {1'b1, 5'd1, 1'b1, 3'b010, 1'b1}) begin
      n_fail++; $display("FAIL addi_ctrl got=%b exp=%b", {ex_valid, ex_rd, ex_alu_src, ex_alu_op, ex_reg_write}, {1'b1, 5'd1, 1'b1, 3'b010, 1'b1}); end
    n_checks++; if (ex_imm !== 64'd5) begin n_fail++; $display("FAIL addi_imm got=%0h exp=5", ex_imm); end
    n_checks++; if (ex_pc !== 64'h40) begin n_fail++; $display("FAIL addi_ex_pc got=%0h exp=40", ex_pc); end
  endtask

  task automatic test_load_use();
    flush();
    drive(e_d(11'h7C2, 5'd2, 5'd1, 9'h1F8), 64'h80, 1'b1);
    tick();
    drive(e_r(11'h558, 5'd3, 5'd2, 5'd4), 64'h84, 1'b1);
    tick();
    drive(e_r(11'h450, 5'd5, 5'd6, 5'd7), 64'h88, 1'b1);
    #1;
    n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL lu_stall got=%0h exp=1", stall_out); end
    n_checks++; if ({ex_mem_read, ex_mem_to_reg, ex_rd} !== {1'b1, 1'b1, 5'd2}) begin
      n_fail++; $display("FAIL lu_ldur_ctrl got=%b exp=%b", {ex_mem_read, ex_mem_to_reg, ex_rd}, {1'b1, 1'b1, 5'd2}); end
    n_checks++; if (ex_imm !== 64'hFFFF_FFFF_FFFF_FFF8) begin n_fail++; $display("FAIL lu_imm got=%0h exp=fffffffffffffff8", ex_imm); end
    tick();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got=%0h exp=0", ex_valid); end
    n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL lu_one_cycle got=%0h exp=0", stall_out); end
    n_checks++; if (id_pc !== 64'h84) begin n_fail++; $display("FAIL lu_hold got=%0h exp=84", id_pc); end
    tick();
    n_checks++; if ({ex_valid, ex_rd, ex_set_flags, ex_pc} !== {1'b1, 5'd3, 1'b1, 64'h84}) begin
      n_fail++; $display("FAIL lu_adds got=%0h exp=%0h", {ex_valid, ex_rd, ex_set_flags, ex_pc}, {1'b1, 5'd3, 1'b1, 64'h84}); end
    flush();
    drive(e_d(11'h7C2, 5'd31, 5'd1, 9'd0), 64'h90, 1'b1);
    tick();
    drive(e_r(11'h558, 5'd3, 5'd31, 5'd31), 64'h94, 1'b1);
    tick();
    n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL lu_xzr got=%0h exp=0", stall_out); end
  endtask

  task automatic test_blt_bypass();
    flush();
    drive(e_r(11'h758, 5'd1, 5'd2, 5'd3), 64'h100, 1'b1);
    tick();
    drive(e_bc(19'h7FFFE, 4'hB), 64'h104, 1'b1);
    tick();
    ex_flags = 4'b1000; ex_flags_we = 1'b1;
    drive(e_addi(5'd9, 5'd0, 12'd1), 64'h108, 1'b1);
    #1;
    n_checks++; if ({BrTaken, UncondBr} !== 2'b10) begin n_fail++; $display("FAIL blt_bypass got=%b exp=10", {BrTaken, UncondBr}); end
    n_checks++; if (id_pc !== 64'h104) begin n_fail++; $display("FAIL blt_id_pc got=%0h exp=104", id_pc); end
    tick();
    ex_flags_we = 1'b0;
    drive(32'd0, 64'd0, 1'b0);
    #1;
    n_checks++; if ({ex_valid, ex_reg_write, ex_pc, BrTaken} !== {1'b1, 1'b0, 64'h104, 1'b0}) begin
      n_fail++; $display("FAIL blt_in_ex got=%0h exp=%0h", {ex_valid, ex_reg_write, ex_pc, BrTaken}, {1'b1, 1'b0, 64'h104, 1'b0}); end
    tick();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL blt_squash got=%0h exp=0", ex_valid); end
    drive(e_bc(19'd4, 4'hB), 64'h140, 1'b1);
    tick();
    drive(32'd0, 64'd0, 1'b0);
    #1;
    n_checks++; if (BrTaken !== 1'b1) begin n_fail++; $display("FAIL blt_stored got=%0h exp=1", BrTaken); end
    ex_flags = 4'b1001; ex_flags_we = 1'b1;
    #1;
    n_checks++; if (BrTaken !== 1'b0) begin n_fail++; $display("FAIL blt_nv_equal got=%0h exp=0", BrTaken); end
    ex_flags_we = 1'b0;
    flush();
  endtask

  task automatic test_cbz();
    flush();
    drive(e_cbz(19'd8, 5'd3), 64'h300, 1'b1);
    tick();
    drive(e_addi(5'd8, 5'd0, 12'd2), 64'h304, 1'b1);
    rt_zero = 1'b0;
    #1;
    n_checks++; if (rd_addr2 !== 5'd3) begin n_fail++; $display("FAIL cbz_reg2loc got=%0d exp=3", rd_addr2); end
    n_checks++; if (BrTaken !== 1'b0) begin n_fail++; $display("FAIL cbz_nz got=%0h exp=0", BrTaken); end
    rt_zero = 1'b1;
    #1;
    n_checks++; if ({BrTaken, UncondBr} !== 2'b10) begin n_fail++; $display("FAIL cbz_z got=%b exp=10", {BrTaken, UncondBr}); end
    tick();
    rt_zero = 1'b0;
    drive(32'd0, 64'd0, 1'b0);
    tick();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL cbz_squash got=%0h exp=0", ex_valid); end
  endtask

  task automatic test_b();
    flush();
    drive(e_b(26'h3FF_FFFF), 64'h200, 1'b1);
    tick();
    drive(e_addi(5'd7, 5'd0, 12'd3), 64'h204, 1'b1);
    #1;
    n_checks++; if ({BrTaken, UncondBr} !== 2'b11) begin n_fail++; $display("FAIL b_taken got=%b exp=11", {BrTaken, UncondBr}); end
    n_checks++; if (id_pc !== 64'h200) begin n_fail++; $display("FAIL b_id_pc got=%0h exp=200", id_pc); end
    tick();
    drive(32'd0, 64'd0, 1'b0);
    n_checks++; if ({ex_valid, ex_pc} !== {1'b1, 64'h200}) begin n_fail++; $display("FAIL b_in_ex got=%0h exp=%0h", {ex_valid, ex_pc}, {1'b1, 64'h200}); end
    tick();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL b_squash got=%0h exp=0", ex_valid); end
  endtask

  task automatic test_illegal();
    logic [31:0] bad;
    bad = {11'h7FF, 21'h0};
    flush();
    drive(bad, 64'h400, 1'b1);
    tick();
    drive(32'd0, 64'd0, 1'b0);
    tick();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL ill_bubble got=%0h exp=0", ex_valid); end
    n_checks++; if (illegal_op !== exp_ill_en) begin n_fail++; $display("FAIL ill_set got=%0h exp=%0h", illegal_op, exp_ill_en); end
    repeat (3) tick();
    n_checks++; if (illegal_op !== exp_ill_en) begin n_fail++; $display("FAIL ill_sticky got=%0h exp=%0h", illegal_op, exp_ill_en); end
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++; if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL ill_reset got=%0h exp=0", illegal_op); end
  endtask

  // ---------------- transaction-level reference ----------------
  typedef enum int {K_NONE, K_ADDI, K_ADDS, K_SUBS, K_AND, K_EOR, K_LSR, K_LDUR, K_STUR, K_B, K_BC, K_CBZ} kind_e;
  typedef struct packed {
    logic v; logic [63:0] pc; logic [4:0] rd; logic [63:0] imm; logic [5:0] sh; logic [2:0] op;
    logic src, mr, mw, m2r, rw, sf;
  } exb_t;

  function automatic kind_e kind_of(input logic [31:0] i);
    if (i[31:22] == 10'h244) return K_ADDI;
    if (i[31:26] == 6'h05) return K_B;
    if (i[31:24] == 8'h54) return K_BC;
    if (i[31:24] == 8'hB4) return K_CBZ;
    case (i[31:21])
      11'h558: return K_ADDS;
      11'h758: return K_SUBS;
      11'h450: return K_AND;
      11'h650: return K_EOR;
      11'h69A: return K_LSR;
      11'h7C2: return K_LDUR;
      11'h7C0: return K_STUR;
      default: return K_NONE;
    endcase
  endfunction

  function automatic exb_t ref_ex(input logic v, input logic [31:0] i, input logic [63:0] pc);
    exb_t e;
    kind_e k;
    longint simm;
    e = '0;
    k = kind_of(i);
    if (!v || k == K_NONE) return e;
    e.v = 1'b1; e.pc = pc;
    simm = longint'($signed(i[20:12]));
    if (k != K_B && k != K_BC && k != K_CBZ) e.rd = i[4:0];
    case (k)
      K_ADDI: begin e.imm = 64'(i[21:10]); e.src = 1; e.op = 3'd2; e.rw = 1; end
      K_ADDS: begin e.op = 3'd2; e.rw = 1; e.sf = 1; end
      K_SUBS: begin e.op = 3'd3; e.rw = 1; e.sf = 1; end
      K_AND:  begin e.op = 3'd4; e.rw = 1; end
      K_EOR:  begin e.op = 3'd6; e.rw = 1; end
      K_LSR:  begin e.sh = i[15:10]; e.rw = 1; end
      K_LDUR: begin e.imm = 64'(simm); e.src = 1; e.op = 3'd2; e.mr = 1; e.m2r = 1; e.rw = 1; end
      K_STUR: begin e.imm = 64'(simm); e.src = 1; e.op = 3'd2; e.mw = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [4:0] rnd_reg();
    if ($urandom_range(0, 7) == 0) return 5'd31;
    return 5'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] raw;
    raw = $urandom;
    case ($urandom_range(0, 12))
      0:  return e_addi(rnd_reg(), rnd_reg(), raw[11:0]);
      1:  return e_r(11'h558, rnd_reg(), rnd_reg(), rnd_reg());
      2:  return e_r(11'h758, rnd_reg(), rnd_reg(), rnd_reg());
      3:  return e_r(11'h450, rnd_reg(), rnd_reg(), rnd_reg());
      4:  return e_r(11'h650, rnd_reg(), rnd_reg(), rnd_reg());
      5:  return {11'h69A, raw[20:16], raw[15:10], rnd_reg(), rnd_reg()};
      6:  return e_d(11'h7C2, rnd_reg(), rnd_reg(), raw[8:0]);
      7:  return e_d(11'h7C0, rnd_reg(), rnd_reg(), raw[8:0]);
      8:  return e_b(raw[25:0]);
      9:  return e_bc(raw[18:0], raw[31] ? 4'hB : raw[3:0]);
      10: return e_cbz(raw[18:0], rnd_reg());
      11: return {11'h7FF, raw[20:0]};
      default: return raw;
    endcase
  endfunction

  task automatic test_random();
    logic        m_v, m_ill, hz, tk, uc, lt, r1use, r2use;
    logic [31:0] m_i;
    logic [63:0] m_pc;
    logic [3:0]  m_fl, fl;
    logic [4:0]  r2;
    exb_t        m_ex, act;
    kind_e       k;
    reset = 1'b1; tick(); reset = 1'b0;
    m_v = 0; m_i = '0; m_pc = '0; m_ex = '0; m_fl = '0; m_ill = 0;
    for (int c = 0; c < 400; c++) begin
      reset       = ($urandom_range(0, 49) == 0);
      drive(rnd_instr(), {$urandom, $urandom}, $urandom_range(0, 3) != 0);
      ex_flags    = 4'($urandom_range(0, 15));
      ex_flags_we = 1'($urandom_range(0, 1));
      rt_zero     = 1'($urandom_range(0, 1));
      #1;
      k     = kind_of(m_i);
      r1use = k inside {K_ADDI, K_ADDS, K_SUBS, K_AND, K_EOR, K_LSR, K_LDUR, K_STUR};
      r2use = k inside {K_ADDS, K_SUBS, K_AND, K_EOR, K_STUR, K_CBZ};
      r2    = (k == K_STUR || k == K_CBZ) ? m_i[4:0] : m_i[20:16];
      hz    = m_v && m_ex.mr && m_ex.rd != 5'd31 &&
              ((r1use && m_i[9:5] == m_ex.rd) || (r2use && r2 == m_ex.rd));
      fl    = ex_flags_we ? ex_flags : m_fl;
      lt    = (fl[3] != fl[0]);
      tk = 0; uc = 0;
      if (m_v && !hz) begin
        if (k == K_B) begin tk = 1; uc = 1; end
        else if (k == K_BC) tk = (m_i[3:0] == 4'hB) && lt;
        else if (k == K_CBZ) tk = rt_zero;
      end
      act = {ex_valid, ex_pc, ex_rd, ex_imm, ex_shamt, ex_alu_op, ex_alu_src, ex_mem_read,
             ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_set_flags};
      n_checks++; if (act !== m_ex) begin n_fail++; $display("FAIL rnd_idex cyc=%0d got=%h exp=%h", c, act, m_ex); end
      n_checks++; if ({stall_out, BrTaken, UncondBr} !== {hz, tk, uc}) begin
        n_fail++; $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", c, {stall_out, BrTaken, UncondBr}, {hz, tk, uc}); end
      n_checks++; if (illegal_op !== m_ill) begin n_fail++; $display("FAIL rnd_illegal cyc=%0d got=%0h exp=%0h", c, illegal_op, m_ill); end
      if (m_v) begin
        n_checks++; if ({rd_addr1, rd_addr2, id_pc} !== {m_i[9:5], r2, m_pc}) begin
          n_fail++; $display("FAIL rnd_id cyc=%0d got=%h exp=%h", c, {rd_addr1, rd_addr2, id_pc}, {m_i[9:5], r2, m_pc}); end
      end
      if (reset) begin
        m_v = 0; m_i = '0; m_pc = '0; m_ex = '0; m_fl = '0; m_ill = 0;
      end else begin
        if (ex_flags_we && m_ex.v) m_fl = ex_flags;
        if (exp_ill_en && m_v && k == K_NONE) m_ill = 1;
        if (hz) m_ex = '0;
        else begin
          m_ex = ref_ex(m_v, m_i, m_pc);
          m_v = if_valid && !tk; m_i = if_instr; m_pc = if_pc;
        end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
`ifdef ILLEGAL_TRAP_EN
    exp_ill_en = 1'b1;
`else
    exp_ill_en = 1'b0;
`endif
    reset = 1'b1; ex_flags = '0; ex_flags_we = 1'b0; rt_zero = 1'b0;
    drive(32'd0, 64'd0, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    test_reset();
    test_addi();
    test_load_use();
    test_blt_bypass();
    test_cbz();
    test_b();
    test_illegal();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
